// File: rtl/foc_seq_pkg.sv
// Shared types and constants for the FOC sample sequencer.
package foc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_READY,
    FAULT
  } seq_state_t;

  localparam int OVR_W = 8;

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/foc_period_timer.sv
// PWM-period tick generator: cnt runs 0..periodTop-1 and ticks on the last count.
module foc_period_timer #(
  parameter int D_WIDTH = 19
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] periodTop,
  output logic               tick
);

  logic [D_WIDTH-1:0] cnt;
  logic               run;

  assign run = enable && (periodTop != '0);
  // >= rather than == so a period shortened below cnt still wraps promptly
  assign tick = run && (cnt >= (periodTop - D_WIDTH'(1)));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + D_WIDTH'(1);
    end
  end

endmodule

// File: rtl/foc_sample_sequencer.sv
// Initiator side of the FOC core sample handshake: captures ADC/resolver data on
// each PWM tick, strobes valid once, then waits for the core's ready rising edge.
//   state      | meaning
//   IDLE       | sequencing disabled
//   WAIT_TICK  | armed, capture on next period tick
//   ISSUE      | one-cycle valid strobe
//   WAIT_READY | waiting for ready rising edge, timeout running
//   FAULT      | timed out, parked until clr_fault
module foc_sample_sequencer
  import foc_seq_pkg::*;
#(
  parameter int D_WIDTH  = 19,
  parameter int Q_BITS   = 15,
  parameter int DERIVE_C = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic               clr_fault,
  input  logic [D_WIDTH-1:0] periodTop,
  input  logic [D_WIDTH-1:0] currA_raw,
  input  logic [D_WIDTH-1:0] currB_raw,
  input  logic [D_WIDTH-1:0] currC_raw,
  input  logic [D_WIDTH-1:0] angle_raw,
  input  logic               ready,
  output logic               valid,
  output logic [D_WIDTH-1:0] currA_out,
  output logic [D_WIDTH-1:0] currB_out,
  output logic [D_WIDTH-1:0] currC_out,
  output logic [D_WIDTH-1:0] angle_out,
  output logic               busy,
  output logic               fault_timeout,
  output logic [OVR_W-1:0]   overrun_cnt
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic signed [D_WIDTH+1:0] C_MAX = (D_WIDTH + 2)'(sat_max(D_WIDTH));
  localparam logic signed [D_WIDTH+1:0] C_MIN = (D_WIDTH + 2)'(sat_min(D_WIDTH));

  generate
    if (Q_BITS >= D_WIDTH || TIMEOUT < 2) begin : g_param_check
      $error("foc_sample_sequencer: Q_BITS must be below D_WIDTH and TIMEOUT at least 2");
    end
  endgenerate

  seq_state_t state, state_nx;
  logic tick, ready_q, rdy_rise, cap_en, fault_set, lost_tick;
  logic [TO_W-1:0] to_cnt;
  logic signed [D_WIDTH:0]   sum_ab;
  logic signed [D_WIDTH+1:0] neg_ab;
  logic [D_WIDTH-1:0]        c_sat, c_next;

  foc_period_timer #(.D_WIDTH(D_WIDTH)) u_timer (
    .clk       (clk),
    .rstb      (rstb),
    .enable    (enable),
    .periodTop (periodTop),
    .tick      (tick)
  );

  assign rdy_rise  = ready && !ready_q;
  assign lost_tick = tick && (state inside {ISSUE, WAIT_READY, FAULT});
  assign valid     = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == WAIT_READY);

  // -(A+B) cannot overflow D_WIDTH+2 bits, so clamp only once at the end
  assign sum_ab = $signed({currA_raw[D_WIDTH-1], currA_raw}) + $signed({currB_raw[D_WIDTH-1], currB_raw});
  assign neg_ab = -$signed({sum_ab[D_WIDTH], sum_ab});

  always_comb begin
    c_sat = neg_ab[D_WIDTH-1:0];
    if (neg_ab > C_MAX) begin
      c_sat = C_MAX[D_WIDTH-1:0];
    end else if (neg_ab < C_MIN) begin
      c_sat = C_MIN[D_WIDTH-1:0];
    end
  end

  assign c_next = (DERIVE_C != 0) ? c_sat : currC_raw;

  always_comb begin
    state_nx  = state;
    cap_en    = 1'b0;
    fault_set = 1'b0;
    case (state)
      IDLE:       if (enable) state_nx = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (tick) begin
          cap_en   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE:      state_nx = WAIT_READY;
      WAIT_READY: begin
        if (rdy_rise) begin
          state_nx = enable ? WAIT_TICK : IDLE;
        end else if (to_cnt == '0) begin
          fault_set = 1'b1;
          state_nx  = FAULT;
        end
      end
      FAULT:      if (clr_fault) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= ready;
    end
  end

  // Down-count from the valid cycle so the fault lands exactly TIMEOUT cycles later
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      to_cnt <= '0;
    end else if (cap_en) begin
      to_cnt <= TO_W'(TIMEOUT - 1);
    end else if ((state == ISSUE || state == WAIT_READY) && to_cnt != '0) begin
      to_cnt <= to_cnt - TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      currA_out <= '0;
      currB_out <= '0;
      currC_out <= '0;
      angle_out <= '0;
    end else if (cap_en) begin
      currA_out <= currA_raw;
      currB_out <= currB_raw;
      currC_out <= c_next;
      angle_out <= angle_raw;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fault_timeout <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      if (fault_set) begin
        fault_timeout <= 1'b1;
      end else if (clr_fault) begin
        fault_timeout <= 1'b0;
      end
      if (clr_fault) begin
        overrun_cnt <= '0;
      end else if (lost_tick && overrun_cnt != '1) begin
        overrun_cnt <= overrun_cnt + OVR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_foc_sample_sequencer.sv
// Self-checking bench for foc_sample_sequencer: per-scenario tasks compare the DUT
// against period/timeout arithmetic and a saturating -(A+B) reference.
module tb_foc_sample_sequencer;

  localparam int DW       = 19;
  localparam int DERIVE_C = 1;
  localparam int TMO      = 1024;
  localparam int CMAX     = (1 << (DW - 1)) - 1;
  localparam int CMIN     = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          rstb, enable, clr_fault, ready;
  logic [DW-1:0] periodTop, currA_raw, currB_raw, currC_raw, angle_raw;
  logic          valid, busy, fault_timeout;
  logic [DW-1:0] currA_out, currB_out, currC_out, angle_out;
  logic [7:0]    overrun_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] prev_a, prev_b, prev_c, prev_ang;
  logic [DW-1:0] ea, eb, ec, eang;
  int            fix_mode = 0;
  logic [DW-1:0] fix_a, fix_b;

  foc_sample_sequencer #(
    .D_WIDTH  (DW),
    .Q_BITS   (15),
    .DERIVE_C (DERIVE_C),
    .TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .enable        (enable),
    .clr_fault     (clr_fault),
    .periodTop     (periodTop),
    .currA_raw     (currA_raw),
    .currB_raw     (currB_raw),
    .currC_raw     (currC_raw),
    .angle_raw     (angle_raw),
    .ready         (ready),
    .valid         (valid),
    .currA_out     (currA_out),
    .currB_out     (currB_out),
    .currC_out     (currC_out),
    .angle_out     (angle_out),
    .busy          (busy),
    .fault_timeout (fault_timeout),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_c_of(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
    int s;
    if (DERIVE_C == 0) return c;
    s = -($signed(a) + $signed(b));
    if (s > CMAX) s = CMAX;
    if (s < CMIN) s = CMIN;
    return DW'(s);
  endfunction

  // Remember last cycle's inputs (what a capture this cycle must show), then drive new ones
  task automatic drive_inputs();
    prev_a   = currA_raw;
    prev_b   = currB_raw;
    prev_c   = currC_raw;
    prev_ang = angle_raw;
    if (fix_mode != 0) begin
      currA_raw = fix_a;
      currB_raw = fix_b;
    end else begin
      currA_raw = DW'($urandom);
      currB_raw = DW'($urandom);
    end
    currC_raw = DW'($urandom);
    angle_raw = DW'($urandom);
  endtask

  task automatic capture_expect();
    ea   = prev_a;
    eb   = prev_b;
    ec   = exp_c_of(prev_a, prev_b, prev_c);
    eang = prev_ang;
  endtask

  task automatic clear_expect();
    ea = '0; eb = '0; ec = '0; eang = '0;
  endtask

  // Leaves the bench 1 time unit into cycle 0: rstb released, enable high, cnt at 0
  task automatic start_run(input int p);
    rstb = 1'b0; enable = 1'b0; ready = 1'b0; clr_fault = 1'b0;
    periodTop = DW'(p);
    clear_expect();
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0; enable = 1'b1; ready = 1'b1; clr_fault = 1'b0;
    periodTop = DW'(5);
    drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (fault_timeout !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault_timeout); end
    checks++;
    if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovr got %0d exp 0", overrun_cnt); end
    checks++;
    if ({currA_out, currB_out, currC_out, angle_out} !== {4 * DW{1'b0}}) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", currA_out, currB_out, currC_out, angle_out);
    end
  endtask

  task automatic test_periodic(input int p, input int nper, input int dly, input int fm,
                               input int fa, input int fb);
    logic ev, ebz;
    fix_mode = fm; fix_a = DW'(fa); fix_b = DW'(fb);
    start_run(p);
    for (int c = 0; c < (nper + 1) * p; c++) begin
      drive_inputs();
      ready = (c >= p) && ((c % p == dly) || (c % p == dly + 1));
      @(negedge clk);
      ev  = (c >= p) && (c % p == 0);
      ebz = (c >= p) && (c % p <= dly);
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL periodic_valid p=%0d c=%0d got %b exp %b", p, c, valid, ev); end
      checks++;
      if (busy !== ebz) begin errors++; $display("FAIL periodic_busy p=%0d c=%0d got %b exp %b", p, c, busy, ebz); end
      checks++;
      if ({fault_timeout, overrun_cnt} !== 9'd0) begin
        errors++; $display("FAIL periodic_flags p=%0d c=%0d got fault=%b ovr=%0d exp 0/0", p, c, fault_timeout, overrun_cnt);
      end
      checks++;
      if ({currA_out, currB_out, currC_out, angle_out} !== {ea, eb, ec, eang}) begin
        errors++; $display("FAIL periodic_data p=%0d c=%0d got %h %h %h %h exp %h %h %h %h",
                           p, c, currA_out, currB_out, currC_out, angle_out, ea, eb, ec, eang);
      end
      @(posedge clk); #1;
    end
    fix_mode = 0;
  endtask

  task automatic test_timeout(input int p);
    int c0, x, eo;
    logic ev, ef, ebz;
    start_run(p);
    c0 = p + TMO + $urandom_range(2, 40);
    for (int c = 0; c <= c0; c++) begin
      drive_inputs();
      ready = 1'b0;
      clr_fault = (c == c0);
      @(negedge clk);
      ev  = (c == p);
      ef  = (c >= p + TMO);
      ebz = (c >= p) && (c < p + TMO);
      eo  = c / p - 1;
      if (eo < 0) eo = 0;
      if (eo > 255) eo = 255;
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL timeout_valid p=%0d c=%0d got %b exp %b", p, c, valid, ev); end
      checks++;
      if (busy !== ebz) begin errors++; $display("FAIL timeout_busy p=%0d c=%0d got %b exp %b", p, c, busy, ebz); end
      checks++;
      if (fault_timeout !== ef) begin errors++; $display("FAIL timeout_fault p=%0d c=%0d got %b exp %b", p, c, fault_timeout, ef); end
      checks++;
      if (overrun_cnt !== 8'(eo)) begin errors++; $display("FAIL timeout_ovr p=%0d c=%0d got %0d exp %0d", p, c, overrun_cnt, eo); end
      checks++;
      if ({currA_out, currB_out, currC_out, angle_out} !== {ea, eb, ec, eang}) begin
        errors++; $display("FAIL timeout_data p=%0d c=%0d got %h %h exp %h %h", p, c, currA_out, currC_out, ea, ec);
      end
      @(posedge clk); #1;
    end
    x = c0 + 2;
    while ((x + 1) % p != 0) x++;
    for (int c = c0 + 1; c <= x + 1; c++) begin
      drive_inputs();
      clr_fault = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      ev = (c == x + 1);
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL resume_valid p=%0d c=%0d got %b exp %b", p, c, valid, ev); end
      checks++;
      if ({fault_timeout, overrun_cnt} !== 9'd0) begin
        errors++; $display("FAIL resume_flags p=%0d c=%0d got fault=%b ovr=%0d exp 0/0", p, c, fault_timeout, overrun_cnt);
      end
      checks++;
      if ({currA_out, currB_out, currC_out, angle_out} !== {ea, eb, ec, eang}) begin
        errors++; $display("FAIL resume_data p=%0d c=%0d got %h %h exp %h %h", p, c, currA_out, currC_out, ea, ec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overrun(input int p, input int d);
    int r, x, vn, hi, eo;
    logic ev, ebz;
    start_run(p);
    r = p + d;
    x = r + 1;
    while ((x + 1) % p != 0) x++;
    vn = x + 1;
    for (int c = 0; c <= vn; c++) begin
      drive_inputs();
      ready = (c >= r);
      @(negedge clk);
      ev  = (c == p) || (c == vn);
      ebz = ((c >= p) && (c <= r)) || (c == vn);
      hi  = (c - 1 < r) ? c - 1 : r;
      eo  = (hi < p) ? 0 : (hi + 1) / p - 1;
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL overrun_valid p=%0d d=%0d c=%0d got %b exp %b", p, d, c, valid, ev); end
      checks++;
      if (busy !== ebz) begin errors++; $display("FAIL overrun_busy p=%0d d=%0d c=%0d got %b exp %b", p, d, c, busy, ebz); end
      checks++;
      if (overrun_cnt !== 8'(eo)) begin errors++; $display("FAIL overrun_cnt p=%0d d=%0d c=%0d got %0d exp %0d", p, d, c, overrun_cnt, eo); end
      checks++;
      if ({currA_out, currB_out, currC_out, angle_out} !== {ea, eb, ec, eang}) begin
        errors++; $display("FAIL overrun_data p=%0d c=%0d got %h %h exp %h %h", p, c, currA_out, currC_out, ea, ec);
      end
      @(posedge clk); #1;
    end
  endtask

  // Ready rises during ISSUE and stays high: only the later low-to-high edge completes
  task automatic test_stale_ready(input int p);
    int r, eo;
    logic ev, ebz;
    start_run(p);
    r = 2 * p + $urandom_range(0, 20);
    for (int c = 0; c <= 3 * p; c++) begin
      drive_inputs();
      ready = ((c >= p) && (c <= r - 3)) || (c >= r);
      @(negedge clk);
      ev  = (c == p) || (c == 3 * p);
      ebz = ((c >= p) && (c <= r)) || (c == 3 * p);
      eo  = (c >= 2 * p) ? 1 : 0;
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL stale_valid p=%0d c=%0d got %b exp %b", p, c, valid, ev); end
      checks++;
      if (busy !== ebz) begin errors++; $display("FAIL stale_busy p=%0d c=%0d got %b exp %b", p, c, busy, ebz); end
      checks++;
      if (overrun_cnt !== 8'(eo)) begin errors++; $display("FAIL stale_ovr p=%0d c=%0d got %0d exp %0d", p, c, overrun_cnt, eo); end
      checks++;
      if ({currA_out, currB_out, currC_out, angle_out} !== {ea, eb, ec, eang}) begin
        errors++; $display("FAIL stale_data p=%0d c=%0d got %h %h exp %h %h", p, c, currA_out, currC_out, ea, ec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid(input int p);
    int k;
    logic ev;
    start_run(p);
    k = $urandom_range(2, 15);
    for (int c = 0; c < p + k; c++) begin
      drive_inputs();
      ready = 1'b0;
      @(negedge clk);
      ev = (c == p);
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL rstmid_pre_valid p=%0d c=%0d got %b exp %b", p, c, valid, ev); end
      @(posedge clk); #1;
    end
    #2;
    rstb = 1'b0;
    #1;
    clear_expect();
    checks++;
    if ({valid, busy, fault_timeout} !== 3'b000) begin
      errors++; $display("FAIL rstmid_ctrl got valid=%b busy=%b fault=%b exp 000", valid, busy, fault_timeout);
    end
    checks++;
    if ({currA_out, currB_out, currC_out, angle_out, overrun_cnt} !== {4 * DW + 8{1'b0}}) begin
      errors++; $display("FAIL rstmid_data got %h %h %h %h ovr=%0d exp 0", currA_out, currB_out, currC_out, angle_out, overrun_cnt);
    end
    @(posedge clk); #1;
    rstb = 1'b1;
    for (int c = 0; c <= p + p / 2; c++) begin
      drive_inputs();
      @(negedge clk);
      ev = (c == p);
      if (ev) capture_expect();
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL rstmid_post_valid p=%0d c=%0d got %b exp %b", p, c, valid, ev); end
      checks++;
      if ({currA_out, currB_out, currC_out, angle_out} !== {ea, eb, ec, eang}) begin
        errors++; $display("FAIL rstmid_post_data p=%0d c=%0d got %h %h exp %h %h", p, c, currA_out, currC_out, ea, ec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_period_zero();
    start_run(0);
    for (int c = 0; c < 300; c++) begin
      drive_inputs();
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL pzero_valid c=%0d got valid=%b busy=%b exp 00", c, valid, busy); end
      checks++;
      if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL pzero_ovr c=%0d got %0d exp 0", c, overrun_cnt); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int p;
    rstb = 1'b0; enable = 1'b0; clr_fault = 1'b0; ready = 1'b0;
    periodTop = '0; currA_raw = '0; currB_raw = '0; currC_raw = '0; angle_raw = '0;
    clear_expect();
    test_reset();
    test_periodic(100, 3, 20, 1, 16384, -16384);
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(4, 40);
      test_periodic(p, 3, $urandom_range(1, p - 3), 0, 0, 0);
    end
    test_periodic(16, 2, 5, 1, CMAX, CMAX);
    test_periodic(16, 2, 5, 1, CMIN, CMIN);
    test_timeout($urandom_range(3, 40));
    test_overrun(50, 120);
    p = $urandom_range(20, 60);
    test_overrun(p, $urandom_range(p + 1, 3 * p));
    test_stale_ready($urandom_range(30, 50));
    test_reset_mid($urandom_range(20, 40));
    test_period_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
